// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - receiver FSM states, parity modes and bit-period helper
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int unsigned calc_cycle(input int unsigned clk_mhz, input int unsigned baud);
        return (clk_mhz * 32'd1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with bit-centre and bit-end strobes
module uart_baud_cnt #(
    parameter int unsigned CYCLE = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic mid_strobe,
    output logic end_strobe
);

    localparam logic [15:0] MID_CNT  = 16'(CYCLE / 2);
    localparam logic [15:0] LAST_CNT = 16'(CYCLE - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Centre strobe lands on the third vote sample so all samples are available
    assign mid_strobe = enable && !clear && (cnt_q == MID_CNT);
    assign end_strobe = enable && !clear && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver; UART_RX_MAJORITY_EN selects 3-sample voting
module uart_rx_cfg #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_valid,
    input  logic                 rx_data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    import uart_pkg::*;

    localparam int unsigned CYCLE     = calc_cycle(CLK_FRE, BAUD_RATE);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

    logic [1:0] sync_q;
    logic       line;
    logic       line_prev_q;
    logic       falling;
    logic       bit_val;

    uart_state_e state_q, state_d;

    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 frame_done, stop_ok, good, consume, exp_par;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;

    logic cnt_clear, cnt_enable, mid_strobe, end_strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 2'b11;
            line_prev_q <= 1'b1;
        end else begin
            sync_q      <= {sync_q[0], rx_pin};
            line_prev_q <= line;
        end
    end

    assign line    = sync_q[1];
    assign falling = line_prev_q & ~line;

`ifdef UART_RX_MAJORITY_EN
    // hist_q holds the two samples preceding the centre strobe
    logic [1:0] hist_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], line};
        end
    end
    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & line) | (hist_q[0] & line);
`else
    logic samp_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= 1'b1;
        end else begin
            samp_q <= line;
        end
    end
    assign bit_val = samp_q;
`endif

    assign cnt_clear  = (state_q == ST_IDLE);
    assign cnt_enable = (state_q != ST_IDLE);

    uart_baud_cnt #(
        .CYCLE(CYCLE)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .enable    (cnt_enable),
        .mid_strobe(mid_strobe),
        .end_strobe(end_strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (falling) state_d = ST_START;
            ST_START: begin
                if (mid_strobe && bit_val) begin
                    state_d = ST_IDLE;
                end else if (end_strobe) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (end_strobe && (bit_idx_q == LAST_BIT)) begin
                    state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (end_strobe) state_d = ST_STOP;
            ST_STOP:   if (mid_strobe && (stop_idx_q == LAST_STOP)) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign exp_par = (PARITY == PAR_ODD) ? ~(^shift_q) : ^shift_q;

    always_comb begin
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
                par_bad_d  = 1'b0;
                stop_bad_d = 1'b0;
            end
            ST_DATA: begin
                if (mid_strobe) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                if (end_strobe) bit_idx_d = bit_idx_q + 3'd1;
            end
            ST_PARITY: if (mid_strobe) par_bad_d = (bit_val != exp_par);
            ST_STOP: begin
                if (mid_strobe) begin
                    if (!bit_val) stop_bad_d = 1'b1;
                    if (stop_idx_q == LAST_STOP) frame_done = 1'b1;
                end
                if (end_strobe) stop_idx_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Holding register: a word completing while the old one is consumed replaces it
    always_comb begin
        stop_ok = bit_val && !stop_bad_q;
        good    = frame_done && stop_ok && !par_bad_q;
        consume = valid_q && rx_data_ready;
        fe_d    = frame_done && !stop_ok;
        pe_d    = frame_done && par_bad_q;
        ov_d    = 1'b0;
        data_d  = data_q;
        valid_d = valid_q;
        if (good) begin
            if (!valid_q || consume) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            ov_q       <= ov_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
    assign frame_err     = fe_q;
    assign parity_err    = pe_q;
    assign overrun       = ov_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - scoreboard bench for uart_rx_cfg (default and even-parity instances)
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int CYC = 434;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst, rx_a, rx_b, ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

    uart_rx_cfg dut_a (
        .clk(clk), .rst(rst), .rx_pin(rx_a), .rx_data(data_a), .rx_data_valid(valid_a),
        .rx_data_ready(ready_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a)
    );

    uart_rx_cfg #(.PARITY(2)) dut_b (
        .clk(clk), .rst(rst), .rx_pin(rx_b), .rx_data(data_b), .rx_data_valid(valid_b),
        .rx_data_ready(ready_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];

    int   fe_a_n = 0, pe_a_n = 0, ov_a_n = 0, pe_b_n = 0, fe_b_n = 0;
    logic valid_a_d = 1'b0;
    time  t_rise_a = 0;
    time  t_start_a = 0;

    always @(negedge clk) begin
        if (fe_a) fe_a_n <= fe_a_n + 1;
        if (pe_a) pe_a_n <= pe_a_n + 1;
        if (ov_a) ov_a_n <= ov_a_n + 1;
        if (pe_b) pe_b_n <= pe_b_n + 1;
        if (fe_b) fe_b_n <= fe_b_n + 1;
        if (valid_a && !valid_a_d) t_rise_a <= $time;
        valid_a_d <= valid_a;
    end

    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rx_a = v; else rx_b = v;
        repeat (CYC) @(posedge clk);
    endtask

    task automatic drive_frame(input int which, input logic [7:0] d, input bit use_par,
                               input logic par_bit, input logic stop_v);
        @(posedge clk);
        if (which == 0) t_start_a = $time;
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (use_par) drive_bit(which, par_bit);
        drive_bit(which, stop_v);
        drive_bit(which, 1'b1);
    endtask

    task automatic wait_word(input int which, input string name);
        int         n;
        logic       v;
        logic [7:0] exp_w;
        logic [7:0] got;
        n = 0;
        do begin
            @(negedge clk);
            v = (which == 0) ? valid_a : valid_b;
            n++;
        end while (!v && n < 2 * CYC);
        checks++;
        if (v !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid timeout: valid=%b required 1", name, v);
        end else if ((which == 0 && exp_a_q.size() == 0) || (which == 1 && exp_b_q.size() == 0)) begin
            errors++;
            $display("FAIL %s_sb unexpected word %h, nothing expected", name, (which == 0) ? data_a : data_b);
        end else begin
            exp_w = (which == 0) ? exp_a_q.pop_front() : exp_b_q.pop_front();
            got   = (which == 0) ? data_a : data_b;
            if (got !== exp_w) begin
                errors++;
                $display("FAIL %s_data got %h required %h", name, got, exp_w);
            end
        end
    endtask

    task automatic consume(input int which);
        @(posedge clk);
        if (which == 0) ready_a = 1'b1; else ready_b = 1'b1;
        @(posedge clk);
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid_a, fe_a, pe_a, ov_a, data_a} !== 12'h000) begin
            errors++;
            $display("FAIL reset_a outputs got %h required 000", {valid_a, fe_a, pe_a, ov_a, data_a});
        end
        checks++;
        if ({valid_b, fe_b, pe_b, ov_b, data_b} !== 12'h000) begin
            errors++;
            $display("FAIL reset_b outputs got %h required 000", {valid_b, fe_b, pe_b, ov_b, data_b});
        end
        @(posedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_basic();
        int lat;
        exp_a_q.push_back(8'hA5);
        drive_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_word(0, "basic_a5");
        lat = int'((t_rise_a - t_start_a - 10) / 20);
        checks++;
        if (lat < 4115 || lat > 4135) begin
            errors++;
            $display("FAIL basic_latency got %0d clk required 4115..4135 (9.5 bits)", lat);
        end
        @(posedge clk);
        ready_a = 1'b1;
        @(posedge clk);
        ready_a = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_clear valid=%b required 0", valid_a);
        end
    endtask

    task automatic test_parity();
        int base;
        base = pe_b_n;
        drive_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
        checks++;
        if (pe_b_n - base !== 1) begin
            errors++;
            $display("FAIL parity_err_pulse count %0d required 1", pe_b_n - base);
        end
        checks++;
        if (valid_b !== 1'b0) begin
            errors++;
            $display("FAIL parity_bad_valid valid=%b required 0", valid_b);
        end
        exp_b_q.push_back(8'h03);
        drive_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
        wait_word(1, "parity_good");
        checks++;
        if (pe_b_n - base !== 1 || fe_b_n !== 0) begin
            errors++;
            $display("FAIL parity_good_pulses pe %0d fe %0d required 1 0", pe_b_n - base, fe_b_n);
        end
        consume(1);
    endtask

    task automatic test_frame_err();
        int base;
        base = fe_a_n;
        drive_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fe_a_n - base !== 1) begin
            errors++;
            $display("FAIL frame_err_pulse count %0d required 1", fe_a_n - base);
        end
        checks++;
        if (valid_a !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_valid valid=%b required 0", valid_a);
        end
    endtask

    task automatic test_overrun();
        int base;
        exp_a_q.push_back(8'h11);
        drive_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        wait_word(0, "overrun_first");
        base = ov_a_n;
        drive_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ov_a_n - base !== 1) begin
            errors++;
            $display("FAIL overrun_pulse count %0d required 1", ov_a_n - base);
        end
        checks++;
        if (data_a !== 8'h11 || valid_a !== 1'b1) begin
            errors++;
            $display("FAIL overrun_hold data %h valid %b required 11 1", data_a, valid_a);
        end
        consume(0);
    endtask

    task automatic test_glitch();
        int base;
        base = fe_a_n + pe_a_n + ov_a_n;
        @(posedge clk);
        rx_a = 1'b0;
        repeat (100) @(posedge clk);
        rx_a = 1'b1;
        repeat (600) @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0 || (fe_a_n + pe_a_n + ov_a_n) !== base) begin
            errors++;
            $display("FAIL glitch_quiet valid %b pulses %0d required 0 0", valid_a, fe_a_n + pe_a_n + ov_a_n - base);
        end
        exp_a_q.push_back(8'h7E);
        drive_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1);
        wait_word(0, "glitch_7e");
        consume(0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] ff;
        ff = 8'hFF;
        @(posedge clk);
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, ff[i]);
        rx_a = ff[4];
        repeat (150) @(posedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid_a, fe_a, pe_a, ov_a, data_a} !== 12'h000) begin
            errors++;
            $display("FAIL midreset_outputs got %h required 000", {valid_a, fe_a, pe_a, ov_a, data_a});
        end
        @(posedge clk);
        rst = 1'b0;
        repeat (5 * CYC) @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0 || fe_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abandon valid %b fe %b required 0 0", valid_a, fe_a);
        end
        exp_a_q.push_back(8'h0F);
        drive_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1);
        wait_word(0, "midreset_0f");
        consume(0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_mid();
        checks++;
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left a %0d b %0d required 0 0", exp_a_q.size(), exp_b_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50, meaning clock frequency in MHz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning serial baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked; legal values 1 or 2.
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on posedge.
REQ-007 SHALL have port rst, input, 1 bit, meaning reset; synchronous and active-high.
REQ-008 SHALL have port rx_pin, input, 1 bit, meaning asynchronous serial input; idle high.
REQ-009 SHALL have port rx_data, output, DATA_BITS bits, meaning received word, LSB first on the line.
REQ-010 SHALL have port rx_data_valid, output, 1 bit, meaning rx_data holds an unconsumed word.
REQ-011 SHALL have port rx_data_ready, input, 1 bit, meaning the consumer accepts the word.
REQ-012 SHALL have port frame_err, output, 1 bit, meaning a stop bit was sampled low; one-cycle pulse.
REQ-013 SHALL have port parity_err, output, 1 bit, meaning a parity mismatch occurred; one-cycle pulse.
REQ-014 SHALL have port overrun, output, 1 bit, meaning a frame was dropped because the holding register was full; one-cycle pulse.

Function
REQ-015 SHALL compute CYCLE = CLK_FRE*1000000/BAUD_RATE clocks per bit; the bit counter is 16 bits.
REQ-016 SHALL pass rx_pin through a 2-flop synchroniser; edge detection and sampling use only the synchronised signal.
REQ-017 SHALL have FSM states IDLE, START, DATA, PARITY and STOP.
REQ-018 SHALL move IDLE->START on a falling edge of the synchronised line.
REQ-019 SHALL, in START at count CYCLE/2-1, abort to IDLE if the voted value is high (glitch reject); otherwise it realigns so that later samples fall at bit centres.
REQ-020 SHALL take each bit value as the majority vote of 3 samples at counts CYCLE/2-2, CYCLE/2-1 and CYCLE/2.
REQ-021 SHALL, in DATA, shift DATA_BITS bits LSB first and then go to PARITY if PARITY!=0, else to STOP.
REQ-022 SHALL, in PARITY, compare one bit against the odd/even parity of the data; on mismatch it sets parity_err for one cycle at frame end.
REQ-023 SHALL, in STOP, check STOP_BITS bits; any low sample sets frame_err for one cycle and discards the frame.
REQ-024 SHALL leave STOP for IDLE at the mid-point of the last stop bit, so the next start edge is never missed.
REQ-025 SHALL, on a good frame with rx_data_valid=0, load rx_data and set rx_data_valid on the next cycle (latency: last stop-bit centre +1 clk).
REQ-026 SHALL clear rx_data_valid on the cycle after rx_data_valid&&rx_data_ready; rx_data holds stable while valid=1.
REQ-027 SHALL, on a good frame with valid=1 and ready=0, keep the old word, discard the new word and pulse overrun.
REQ-028 SHALL, on a good frame completing in the same cycle as valid&&ready, load the new word, keep valid at 1 and not pulse overrun.
REQ-029 SHALL not load rx_data for a frame with a parity error; the error pulse is still generated.

Reset
REQ-030 SHALL, while rst=1 at a clk edge, force state=IDLE, counters=0, rx_data=0, rx_data_valid=0, frame_err=0, parity_err=0, overrun=0, and set the synchroniser flops to 1.
REQ-031 SHALL, on reset mid-frame, abandon the frame; reception restarts only on a fresh falling edge after rst deasserts.

Configuration
REQ-032 SHALL, with UART_RX_MAJORITY_EN defined, use the 3-sample vote of REQ-020.
REQ-033 SHALL, with UART_RX_MAJORITY_EN undefined, use a single sample at count CYCLE/2-1, with all other timing unchanged.

Structure
REQ-034 SHALL place the state enum, the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and a CYCLE calculation function in package uart_pkg.
REQ-035 SHALL implement the bit-period counter and the sample strobes in sub-module uart_baud_cnt, with inputs clear and enable and outputs mid_strobe and end_strobe.

Verification
REQ-036 SHALL cover: defaults (CYCLE=434), byte 0xA5 with 1 stop bit -> rx_data=0xA5 and valid=1 after 9.5 bit times; ready=1 -> valid=0 on the next cycle.
REQ-037 SHALL cover: PARITY=2, byte 0x03 with parity bit 1 -> parity_err pulse and valid stays 0; with parity bit 0 -> rx_data=0x03.
REQ-038 SHALL cover: stop bit driven low for byte 0x55 -> frame_err pulse and no valid.
REQ-039 SHALL cover: 0x11 then 0x22 with ready held 0 -> overrun pulse and rx_data stays 0x11.
REQ-040 SHALL cover: a 100-clk low glitch on an idle line -> return to IDLE with no outputs asserted; a following 0x7E is received correctly.
REQ-041 SHALL cover: rst asserted during bit 4 of 0xFF -> all outputs 0; the next frame 0x0F is received correctly.
